// File: rtl/round_robin_mux_arbiter.sv
// round_robin_mux_arbiter: 4-way round-robin mux into a one-entry output register.
module round_robin_mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid_i,
  input  logic [4*WIDTH-1:0] in_data_i,
  output logic [3:0]         in_ready_o,
  output logic               out_valid_o,
  output logic [WIDTH-1:0]   out_data_o,
  input  logic               out_ready_i,
  output logic [1:0]         out_src_o
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0] src_q, src_d, last_q, last_d, win;
  logic load_ok, grant;
  // Descending scan so the nearest requester after last wins.
  always_comb begin
    win = last_q;
    for (int k = 4; k >= 1; k--)
      if (in_valid_i[2'(last_q + 2'(k))]) win = 2'(last_q + 2'(k));
  end
  assign load_ok = (state_q == EMPTY) || out_ready_i;
  assign grant = load_ok && |in_valid_i && !rst;
  assign in_ready_o = grant ? 4'(4'd1 << win) : 4'd0;
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    src_d = src_q;
    last_d = last_q;
    if (grant) begin
      state_d = FULL;
      data_d = in_data_i[win*WIDTH +: WIDTH];
      src_d = win;
      last_d = win;
    end else if (state_q == FULL && out_ready_i) begin
      state_d = EMPTY;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q <= '0;
      src_q <= '0;
      last_q <= 2'd3;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      src_q <= src_d;
      last_q <= last_d;
    end
  end
  assign out_valid_o = (state_q == FULL);
  assign out_data_o = data_q;
  assign out_src_o = src_q;
endmodule

// File: doc/round_robin_mux_arbiter.md
ROUND_ROBIN_MUX_ARBITER -- requirements
Module: round_robin_mux_arbiter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, the data width of each requester and of the output.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  4  in_valid[i]=1 means requester i offers a word.
REQ-005 in_data  input  4*WIDTH  requester i word at bits [i*WIDTH +: WIDTH].
REQ-006 in_ready  output  4  in_ready[i]=1 means requester i's word is taken this cycle.
REQ-007 out_valid  output  1  the output register holds a word.
REQ-008 out_data  output  WIDTH  the word in the output register.
REQ-009 out_ready  input  1  the downstream consumer accepts out_data this cycle.
REQ-010 out_src  output  2  index of the requester whose word is in the output register.

Function
REQ-011 A transfer SHALL occur on a channel in any cycle where valid and ready are both 1 at the rising edge.
REQ-012 The block SHALL contain a one-entry output register (out_valid, out_data, out_src) and a 2-bit last-grant pointer, last.
REQ-013 The state SHALL be EMPTY when out_valid=0 and FULL when out_valid=1.
REQ-014 load_ok SHALL be 1 when the state is EMPTY, or when it is FULL and out_ready=1.
REQ-015 The winner SHALL be the first index i with in_valid[i]=1, searched in the order last+1, last+2, last+3, last+4, all modulo 4; the search wraps from 3 to 0.
REQ-016 in_ready[winner] SHALL be 1 only when load_ok=1 and at least one in_valid bit is 1; every other in_ready bit SHALL be 0.
REQ-017 in_ready SHALL be combinational from in_valid, out_ready and the register state; no in_ready bit SHALL depend on in_data.
REQ-018 On an input transfer: out_data SHALL load in_data of the winner, out_src and last SHALL load the winner index, and out_valid SHALL become 1 on the next cycle.
REQ-019 Latency SHALL be exactly 1 cycle from the input transfer to out_valid=1.
REQ-020 On an output transfer with no input transfer in the same cycle, out_valid SHALL become 0; out_data and out_src SHALL hold their values.
REQ-021 An output transfer and an input transfer in the same cycle SHALL reload the register with no bubble, giving a sustained throughput of 1 word per cycle.
REQ-022 When FULL and out_ready=0, out_data, out_src and last SHALL stay stable, and in_ready SHALL be 4'b0000.
REQ-023 When no in_valid bit is 1, last SHALL hold its value and in_ready SHALL be 4'b0000.
REQ-024 A requester SHALL be able to deassert in_valid before it receives in_ready; no word SHALL be taken from a requester whose in_valid=0.
REQ-025 With all four requesters continuously valid and out_ready=1, the grant sequence SHALL be 0,1,2,3,0,... and no requester SHALL wait more than 3 grants.

Reset
REQ-026 While rst=1 at a rising edge: out_valid SHALL be 0, out_data SHALL be 0, out_src SHALL be 0, and last SHALL be 3, so that requester 0 has first priority after reset.
REQ-027 While rst=1, in_ready SHALL be 4'b0000.
REQ-028 A reset asserted while FULL SHALL discard the held word, and no output transfer of that word SHALL be reported.

Verification
REQ-029 Single requester: reset; in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100 in cycle 0; cycle 1 shows out_valid=1, out_data=8'hA5, out_src=2.
REQ-030 All contend: in_valid=4'b1111, data[i]=8'h10+i, out_ready=1 for 8 cycles -> out_data sequence 10,11,12,13,10,11,12,13 with one word per cycle and no gaps.
REQ-031 Backpressure: FULL holding 8'h11 from requester 1, out_ready=0 for 5 cycles, in_valid=4'b1111 -> out_data stays 8'h11 and in_ready=4'b0000 throughout; after out_ready=1 the next word comes from requester 2.
REQ-032 Wrap and skip: last=3, in_valid=4'b1001 -> requester 0 granted, then requester 3, then requester 0.
REQ-033 Reset mid-stream: FULL with out_valid=1, assert rst for 1 cycle -> next cycle out_valid=0, out_data=0, out_src=0; with in_valid=4'b1111, requester 0 is granted first.
REQ-034 Drain: a single word is accepted, then in_valid=0 with out_ready=1 -> out_valid=1 for exactly 1 cycle, then 0, and out_data holds its last value.
